accum_bias_relu: RTL

//  Consumes the N_adder_tree lane partial sums produced by a layer's adder trees,

---
 rtl/accum_bias_relu_pkg.sv | 38 +++
 rtl/accum_bias_lane.sv | 50 +++++
 rtl/accum_bias_relu.sv | 100 ++++++++++
 3 files changed

// File: rtl/accum_bias_relu_pkg.sv
// Shared definitions for the accumulate / bias / ReLU stage: word sizing,
// FSM state encoding and the saturate-then-ReLU helper used by every lane.
package accum_bias_relu_pkg;

    localparam int DEF_DW = 18;

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_FINAL = 2'd1,
        ST_OUT   = 2'd2
    } state_t;

    // Headroom for N_PASSES signed DW-bit terms plus one guard bit.
    function automatic int calc_acc_w(input int dw, input int n_passes);
        return dw + $clog2(n_passes) + 1;
    endfunction

    function automatic int lane_lsb(input int lane, input int dw);
        return lane * dw;
    endfunction

    // Saturate to a signed dw-bit range first, then clamp negatives when ReLU is on.
    function automatic logic signed [63:0] sat_relu(input logic signed [63:0] sum,
                                                    input int dw,
                                                    input logic relu_en);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        logic signed [63:0] r;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        if (sum > hi)      r = hi;
        else if (sum < lo) r = lo;
        else               r = sum;
        if (relu_en && r < 0) r = '0;
        return r;
    endfunction

endpackage

// File: rtl/accum_bias_lane.sv
// One lane: pass accumulator, bias add, saturation and optional ReLU into a
// registered output word.
module accum_bias_lane
    import accum_bias_relu_pkg::*;
#(
    parameter int DW      = DEF_DW,
    parameter int ACC_W   = DEF_DW + 3,
    parameter int RELU_EN = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          acc_en,
    input  logic          acc_clr,
    input  logic [DW-1:0] psum,
    input  logic [DW-1:0] bias,
    input  logic          load,
    output logic [DW-1:0] out_data
);

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic        [DW-1:0]    out_q, out_d;
    logic signed [ACC_W:0]   sum;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        acc_d = acc_q;
        out_d = out_q;
        sum   = (ACC_W+1)'(acc_q) + (ACC_W+1)'($signed(bias));
        if (acc_en) begin
            acc_d = (acc_clr ? '0 : acc_q) + ACC_W'($signed(psum));
        end
        if (load) begin
            out_d = DW'(sat_relu(64'(sum), DW, RELU_EN != 0));
        end
    end

    // NOTE: state registers use non-blocking assignments only, so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            out_q <= '0;
        end else begin
            acc_q <= acc_d;
            out_q <= out_d;
        end
    end

    assign out_data = out_q;

endmodule

// File: rtl/accum_bias_relu.sv
// Accumulates N_PASSES lane-packed partial sums per pixel, then adds bias,
// saturates and applies ReLU; a three-state FSM handles the handshakes.
module accum_bias_relu
    import accum_bias_relu_pkg::*;
#(
    parameter int  N_adder_tree = 16,
    parameter int  DW           = DEF_DW,
    parameter int  N_PASSES     = 4,
    parameter int  RELU_EN      = 1,
    localparam int ACC_W        = calc_acc_w(DW, N_PASSES)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_adder_tree*DW-1:0] bias,
    input  logic [N_adder_tree*DW-1:0] in_psum,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [N_adder_tree*DW-1:0] out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_last
);

    localparam int PCW = (N_PASSES > 1) ? $clog2(N_PASSES) : 1;

    state_t         state_q, state_d;
    logic [PCW-1:0] pass_cnt_q, pass_cnt_d;
    logic           out_valid_q, out_valid_d;
    logic           accept;
    logic           acc_clr;
    logic           load;

    assign in_ready = (state_q == ST_ACCUM);
    assign accept   = in_valid && in_ready;
    assign acc_clr  = (pass_cnt_q == '0);
    assign load     = (state_q == ST_FINAL);

    always_comb begin
        state_d     = state_q;
        pass_cnt_d  = pass_cnt_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ST_ACCUM: begin
                if (accept) begin
                    if (pass_cnt_q == PCW'(N_PASSES - 1)) begin
                        pass_cnt_d = '0;
                        state_d    = ST_FINAL;
                    end else begin
                        pass_cnt_d = pass_cnt_q + PCW'(1);
                    end
                end
            end
            ST_FINAL: begin
                out_valid_d = 1'b1;
                state_d     = ST_OUT;
            end
            ST_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_ACCUM;
                end
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ACCUM;
            pass_cnt_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pass_cnt_q  <= pass_cnt_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Every output beat closes a pixel, so last tracks valid.
    assign out_valid = out_valid_q;
    assign out_last  = out_valid_q;

    for (genvar i = 0; i < N_adder_tree; i++) begin : g_lane
        accum_bias_lane #(
            .DW      (DW),
            .ACC_W   (ACC_W),
            .RELU_EN (RELU_EN)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .acc_en   (accept),
            .acc_clr  (acc_clr),
            .psum     (in_psum[lane_lsb(i, DW) +: DW]),
            .bias     (bias[lane_lsb(i, DW) +: DW]),
            .load     (load),
            .out_data (out_data[lane_lsb(i, DW) +: DW])
        );
    end

endmodule
